// File: rtl/sudoku_pkg.sv
// Shared types, defaults and mask indexing for the sudoku candidate-mask iterator.
package sudoku_pkg;

  localparam int unsigned BOX_DEFAULT      = 3;
  localparam int unsigned MAX_ITER_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Flat bit position of value v at column x, row y for a grid of side s.
  function automatic int unsigned cell_bit(input int unsigned x, input int unsigned y,
                                           input int unsigned v, input int unsigned s);
    return x * s * s + y * s + v;
  endfunction

endpackage

// File: rtl/sudoku_mask_pass.sv
// One combinational elimination pass: naked and hidden singles over rows, columns and boxes.
module sudoku_mask_pass
  import sudoku_pkg::*;
#(
  parameter  int unsigned BOX = BOX_DEFAULT,
  localparam int unsigned S   = BOX * BOX,
  localparam int unsigned W   = S * S * S
) (
  input  logic [W-1:0] cur_mask,
  output logic [W-1:0] next_mask,
  output logic         contradiction,
  output logic         solved
);

  localparam int unsigned BW = $clog2(W);
  localparam int unsigned CW = $clog2(S * S);

  logic [W-1:0]   cand;
  logic [S*S-1:0] single;
  logic [S*S-1:0] empty;

  logic naked;
  logic hid_row;
  logic hid_col;
  logic hid_box;
  logic peer;

  function automatic logic [BW-1:0] bidx(input int unsigned x, input int unsigned y,
                                         input int unsigned v);
    return BW'(cell_bit(x, y, v, S));
  endfunction

  function automatic logic [CW-1:0] cidx(input int unsigned x, input int unsigned y);
    return CW'(x * S + y);
  endfunction

  assign cand = ~cur_mask;

  for (genvar c = 0; c < S * S; c++) begin : g_cell
    assign single[c] = ($countones(cand[c*S +: S]) == 1);
    assign empty[c]  = (cand[c*S +: S] == '0);
  end

  assign contradiction = |empty;
  assign solved        = (&single) & ~contradiction;

  // Accumulate eliminations on top of the current mask; bits are only ever added.
  always_comb begin
    next_mask = cur_mask;
    naked     = 1'b0;
    hid_row   = 1'b0;
    hid_col   = 1'b0;
    hid_box   = 1'b0;
    peer      = 1'b0;
    for (int unsigned x = 0; x < S; x++) begin
      for (int unsigned y = 0; y < S; y++) begin
        for (int unsigned v = 0; v < S; v++) begin
          naked   = 1'b0;
          hid_row = 1'b1;
          hid_col = 1'b1;
          hid_box = 1'b1;
          for (int unsigned x2 = 0; x2 < S; x2++) begin
            for (int unsigned y2 = 0; y2 < S; y2++) begin
              peer = ((x2 == x) || (y2 == y) ||
                      ((x2 / BOX == x / BOX) && (y2 / BOX == y / BOX))) &&
                     !((x2 == x) && (y2 == y));
              if (peer && single[cidx(x2, y2)] && cand[bidx(x2, y2, v)]) naked = 1'b1;
              if (cand[bidx(x2, y2, v)] && !((x2 == x) && (y2 == y))) begin
                if (y2 == y) hid_row = 1'b0;
                if (x2 == x) hid_col = 1'b0;
                if ((x2 / BOX == x / BOX) && (y2 / BOX == y / BOX)) hid_box = 1'b0;
              end
            end
          end
          if (naked) next_mask[bidx(x, y, v)] = 1'b1;
          if (cand[bidx(x, y, v)] && (hid_row || hid_col || hid_box)) begin
            for (int unsigned u = 0; u < S; u++) begin
              if (u != v) next_mask[bidx(x, y, u)] = 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/sudoku_mask_iter.sv
// Iterates the elimination pass on an accepted mask until contradiction, fixpoint or pass limit.
module sudoku_mask_iter
  import sudoku_pkg::*;
#(
  parameter  int unsigned BOX      = BOX_DEFAULT,
  parameter  int unsigned MAX_ITER = MAX_ITER_DEFAULT,
  localparam int unsigned S        = BOX * BOX,
  localparam int unsigned W        = S * S * S
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] mask_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] mask_out,
  output logic         solved,
  output logic         contradiction,
  output logic         timeout,
  output logic [7:0]   iter_count
);

  state_t       state;
  logic [W-1:0] pass_next;
  logic         pass_contradiction;
  logic         pass_solved;
  logic         fixpoint;
  logic         at_limit;

  // mask_out doubles as the working mask register while in RUN.
  sudoku_mask_pass #(.BOX(BOX)) u_pass (
    .cur_mask      (mask_out),
    .next_mask     (pass_next),
    .contradiction (pass_contradiction),
    .solved        (pass_solved)
  );

  assign fixpoint = (pass_next == mask_out);
  assign at_limit = ((iter_count + 8'd1) == 8'(MAX_ITER));

  // Control FSM with registered handshake, mask, flags and pass counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      mask_out      <= '0;
      solved        <= 1'b0;
      contradiction <= 1'b0;
      timeout       <= 1'b0;
      iter_count    <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            mask_out      <= mask_in;
            iter_count    <= 8'd0;
            solved        <= 1'b0;
            contradiction <= 1'b0;
            timeout       <= 1'b0;
            in_ready      <= 1'b0;
            state         <= ST_RUN;
          end
        end
        ST_RUN: begin
          mask_out   <= pass_next;
          iter_count <= iter_count + 8'd1;
          if (pass_contradiction || fixpoint || at_limit) begin
            contradiction <= pass_contradiction;
            solved        <= pass_solved;
            timeout       <= ~pass_contradiction & ~fixpoint;
            out_valid     <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_mask_iter.sv
// Randomized bench for sudoku_mask_iter against a unit-based candidate-set model.
module tb_sudoku_mask_iter;

  localparam int unsigned MW = 729;
  typedef logic [MW-1:0] mask_t;

  typedef struct packed {
    logic       in_ready;
    logic       out_valid;
    logic       solved;
    logic       contradiction;
    logic       timeout;
    logic [7:0] iter;
    mask_t      mask;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic out_ready;
  mask_t mask_in;
  logic iv0, iv1, iv2;
  logic ir0, ir1, ir2;
  logic ov0, ov1, ov2;
  logic sv0, sv1, sv2;
  logic cv0, cv1, cv2;
  logic tv0, tv1, tv2;
  logic [7:0] it0, it1, it2;
  logic [728:0] mo0, mo1;
  logic [63:0]  mo2;

  int n_vec;
  int n_err;

  always #5 clk = ~clk;

  sudoku_mask_iter #(.BOX(3), .MAX_ITER(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .mask_in(mask_in),
    .out_valid(ov0), .out_ready(out_ready), .mask_out(mo0), .solved(sv0),
    .contradiction(cv0), .timeout(tv0), .iter_count(it0));

  sudoku_mask_iter #(.BOX(3), .MAX_ITER(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .mask_in(mask_in),
    .out_valid(ov1), .out_ready(out_ready), .mask_out(mo1), .solved(sv1),
    .contradiction(cv1), .timeout(tv1), .iter_count(it1));

  sudoku_mask_iter #(.BOX(2), .MAX_ITER(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .mask_in(mask_in[63:0]),
    .out_valid(ov2), .out_ready(out_ready), .mask_out(mo2), .solved(sv2),
    .contradiction(cv2), .timeout(tv2), .iter_count(it2));

  task automatic check_eq(input string tag, input mask_t got, input mask_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int box_of(input int d);
    return (d == 2) ? 2 : 3;
  endfunction

  function automatic int maxit_of(input int d);
    return (d == 1) ? 1 : 16;
  endfunction

  function automatic obs_t observe(input int d);
    obs_t o;
    case (d)
      0: o = '{ir0, ov0, sv0, cv0, tv0, it0, mask_t'(mo0)};
      1: o = '{ir1, ov1, sv1, cv1, tv1, it1, mask_t'(mo1)};
      default: o = '{ir2, ov2, sv2, cv2, tv2, it2, mask_t'(mo2)};
    endcase
    return o;
  endfunction

  task automatic set_in_valid(input int d, input logic v);
    case (d)
      0: iv0 = v;
      1: iv1 = v;
      default: iv2 = v;
    endcase
  endtask

  function automatic bit bit_of(input mask_t m, input int i);
    mask_t t;
    t = m >> i;
    return t[0];
  endfunction

  function automatic mask_t set_bit(input mask_t m, input int i);
    return m | (mask_t'(1) << i);
  endfunction

  function automatic mask_t clr_bit(input mask_t m, input int i);
    return m & ~(mask_t'(1) << i);
  endfunction

  function automatic int bpos(input int x, input int y, input int v, input int box);
    return (x * box * box + y) * box * box + v;
  endfunction

  // One pass over candidate sets, unit by unit (rows, columns, boxes).
  function automatic mask_t model_pass(input mask_t m, input int box,
                                       output bit contra, output bit solv);
    int s;
    int unsigned cand [9][9];
    int unsigned rm [9][9];
    int unsigned full;
    int ux [9];
    int uy [9];
    int cnt;
    int who;
    mask_t res;
    s = box * box;
    full = (32'd1 << s) - 32'd1;
    contra = 1'b0;
    solv = 1'b1;
    for (int x = 0; x < s; x++) begin
      for (int y = 0; y < s; y++) begin
        cand[x][y] = 0;
        rm[x][y] = 0;
        for (int v = 0; v < s; v++)
          if (!bit_of(m, bpos(x, y, v, box))) cand[x][y] |= (32'd1 << v);
        if (cand[x][y] == 0) contra = 1'b1;
        if ($countones(cand[x][y]) != 1) solv = 1'b0;
      end
    end
    if (contra) solv = 1'b0;
    for (int u = 0; u < 3 * s; u++) begin
      for (int k = 0; k < s; k++) begin
        case (u / s)
          0: begin ux[k] = k; uy[k] = u % s; end
          1: begin ux[k] = u % s; uy[k] = k; end
          default: begin
            ux[k] = ((u % s) % box) * box + k % box;
            uy[k] = ((u % s) / box) * box + k / box;
          end
        endcase
      end
      for (int a = 0; a < s; a++)
        if ($countones(cand[ux[a]][uy[a]]) == 1)
          for (int b = 0; b < s; b++)
            if (b != a) rm[ux[b]][uy[b]] |= cand[ux[a]][uy[a]];
      for (int v = 0; v < s; v++) begin
        cnt = 0;
        who = 0;
        for (int a = 0; a < s; a++)
          if (((cand[ux[a]][uy[a]] >> v) & 32'd1) != 0) begin
            cnt++;
            who = a;
          end
        if (cnt == 1) rm[ux[who]][uy[who]] |= full & ~(32'd1 << v);
      end
    end
    res = m;
    for (int x = 0; x < s; x++)
      for (int y = 0; y < s; y++)
        for (int v = 0; v < s; v++)
          if (((rm[x][y] >> v) & 32'd1) != 0) res = set_bit(res, bpos(x, y, v, box));
    return res;
  endfunction

  // Repeat passes with the exit priority contradiction, fixpoint, pass limit.
  task automatic model_run(input mask_t m, input int box, input int maxit, output mask_t fin,
                           output int it, output bit sol, output bit con, output bit tmo);
    mask_t cur;
    mask_t nxt;
    bit c;
    bit s;
    cur = m;
    nxt = m;
    it = 0;
    sol = 0;
    con = 0;
    tmo = 0;
    for (int k = 0; k < 256; k++) begin
      nxt = model_pass(cur, box, c, s);
      it++;
      if (c) begin con = 1; sol = 0; break; end
      if (nxt == cur) begin sol = s; break; end
      if (it == maxit) begin tmo = 1; sol = s; break; end
      cur = nxt;
    end
    fin = nxt;
  endtask

  function automatic int sol_val(input int x, input int y, input int box);
    return (box * (y % box) + y / box + x) % (box * box);
  endfunction

  function automatic mask_t solution_mask(input int box);
    mask_t m;
    int s;
    s = box * box;
    m = '0;
    for (int x = 0; x < s; x++)
      for (int y = 0; y < s; y++)
        for (int v = 0; v < s; v++)
          if (v != sol_val(x, y, box)) m = set_bit(m, bpos(x, y, v, box));
    return m;
  endfunction

  function automatic mask_t single_cell(input int x, input int y, input int v, input int box);
    mask_t m;
    m = '0;
    for (int u = 0; u < box * box; u++)
      if (u != v) m = set_bit(m, bpos(x, y, u, box));
    return m;
  endfunction

  function automatic mask_t rand_mask(input int box, input int style);
    mask_t m;
    int s;
    int w;
    s = box * box;
    w = s * s * s;
    m = '0;
    case (style)
      0: begin
        for (int i = 0; i < 23; i++)
          m |= mask_t'($urandom & $urandom & $urandom) << (32 * i);
        m &= (mask_t'(1) << w) - mask_t'(1);
      end
      1: begin
        m = solution_mask(box);
        for (int x = 0; x < s; x++)
          for (int y = 0; y < s; y++)
            if ($urandom_range(0, 2) == 0)
              m = clr_bit(m, bpos(x, y, int'($urandom_range(0, s - 1)), box));
      end
      default: begin
        for (int k = 0; k < int'($urandom_range(2, 8)); k++)
          m |= single_cell(int'($urandom_range(0, s - 1)), int'($urandom_range(0, s - 1)),
                           int'($urandom_range(0, s - 1)), box);
      end
    endcase
    return m;
  endfunction

  // Full transaction on one instance: offer, wait for result, hold, release.
  task automatic run_txn(input int d, input mask_t m, input int hold, input string tag,
                         output obs_t od);
    mask_t em;
    int eit;
    bit es, ec, et;
    obs_t o;
    int lat;
    bit got;
    model_run(m, box_of(d), maxit_of(d), em, eit, es, ec, et);
    mask_in = m;
    out_ready = (hold == 0);
    set_in_valid(d, 1'b1);
    @(posedge clk);
    #1;
    set_in_valid(d, 1'b0);
    o = observe(d);
    check_eq({tag, ".busy"}, mask_t'({o.in_ready, o.out_valid}), mask_t'(0));
    lat = 1;
    got = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      lat++;
      o = observe(d);
      if (o.out_valid) begin got = 1; break; end
    end
    od = o;
    check_eq({tag, ".done"}, mask_t'(got), mask_t'(1));
    if (got) begin
      check_eq({tag, ".lat"}, mask_t'(lat), mask_t'(eit + 1));
      check_eq({tag, ".flags"}, mask_t'({o.in_ready, o.solved, o.contradiction, o.timeout, o.iter}),
               mask_t'({1'b0, es, ec, et, 8'(eit)}));
      check_eq({tag, ".mask"}, o.mask, em);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        o = observe(d);
        check_eq({tag, ".hold"}, mask_t'({o.out_valid, o.solved, o.contradiction, o.timeout, o.iter}),
                 mask_t'({1'b1, es, ec, et, 8'(eit)}));
        check_eq({tag, ".hmask"}, o.mask, em);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      o = observe(d);
      check_eq({tag, ".release"}, mask_t'({o.in_ready, o.out_valid}), mask_t'(2'b10));
    end else begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
    out_ready = 1'b0;
  endtask

  task automatic check_reset(input int d, input string tag);
    obs_t o;
    o = observe(d);
    check_eq({tag, ".rflags"}, mask_t'({o.in_ready, o.out_valid, o.solved, o.contradiction,
                                        o.timeout, o.iter}), mask_t'(13'h1000));
    check_eq({tag, ".rmask"}, o.mask, '0);
  endtask

  // Reset in mid-RUN, then reset coinciding with an offered input.
  task automatic abort_txn(input int d, input mask_t m, input string tag);
    obs_t o;
    mask_in = m;
    out_ready = 1'b1;
    set_in_valid(d, 1'b1);
    @(posedge clk);
    #1;
    set_in_valid(d, 1'b0);
    o = observe(d);
    check_eq({tag, ".run"}, mask_t'(o.in_ready), mask_t'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset(d, {tag, ".abort"});
    set_in_valid(d, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_in_valid(d, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      o = observe(d);
      check_eq({tag, ".noacc"}, mask_t'({o.in_ready, o.out_valid, o.iter}), mask_t'(10'h200));
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    obs_t o;
    mask_t m;
    mask_t e;
    int b;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    out_ready = 1'b0;
    mask_in = '0;
    iv0 = 1'b0;
    iv1 = 1'b0;
    iv2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_reset(d, $sformatf("reset%0d", d));
    rst = 1'b0;

    run_txn(0, '0, 2, "zero", o);
    check_eq("zero.exp", mask_t'({o.iter, o.solved, o.contradiction, o.timeout}), mask_t'(11'h008));
    check_eq("zero.expmask", o.mask, '0);

    m = single_cell(0, 0, 4, 3);
    e = m;
    for (int x = 0; x < 9; x++)
      for (int y = 0; y < 9; y++)
        if ((x == 0 || y == 0 || (x < 3 && y < 3)) && !(x == 0 && y == 0))
          e = set_bit(e, bpos(x, y, 4, 3));
    run_txn(0, m, 1, "naked", o);
    check_eq("naked.expmask", o.mask, e);
    check_eq("naked.exp", mask_t'({o.iter, o.solved, o.contradiction, o.timeout}), mask_t'(11'h010));

    m = single_cell(2, 3, 0, 3);
    m = set_bit(m, bpos(2, 3, 0, 3));
    run_txn(0, m, 0, "contra", o);
    check_eq("contra.exp", mask_t'({o.iter, o.solved, o.contradiction, o.timeout}), mask_t'(11'h00A));

    m = solution_mask(3);
    for (int x = 0; x < 9; x++)
      for (int y = 0; y < 9; y++)
        if (sol_val(x, y, 3) == 0) m = clr_bit(m, bpos(x, y, int'($urandom_range(1, 8)), 3));
    run_txn(0, m, 3, "solve", o);
    check_eq("solve.expmask", o.mask, solution_mask(3));
    check_eq("solve.exp", mask_t'({o.iter, o.solved, o.contradiction, o.timeout}), mask_t'(11'h014));

    run_txn(1, single_cell(0, 0, 4, 3), 2, "limit", o);
    check_eq("limit.exp", mask_t'({o.iter, o.solved, o.contradiction, o.timeout}), mask_t'(11'h009));

    run_txn(0, single_cell(4, 4, 7, 3), 10, "hold3", o);
    abort_txn(0, single_cell(1, 1, 2, 3), "abort3");
    run_txn(2, single_cell(1, 2, 3, 2), 10, "hold2", o);
    abort_txn(2, single_cell(0, 3, 1, 2), "abort2");

    for (int d = 0; d < 3; d++) begin
      b = box_of(d);
      for (int i = 0; i < 25; i++) begin
        m = rand_mask(b, i % 3);
        run_txn(d, m, int'($urandom_range(0, 3)), $sformatf("rnd%0d_%0d", d, i), o);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sudoku_mask_iter.md
SUDOKU_MASK_ITER -- requirements
Module: sudoku_mask_iter

Interface
REQ-001 The block SHALL have parameter BOX, default 3, giving box edge; grid side S=BOX*BOX, mask width W=S*S*S.
REQ-002 The block SHALL have parameter MAX_ITER, default 16, giving the pass limit per puzzle; the legal range is 1..255.
REQ-003 The block SHALL have port clk, input, 1, the only clock.
REQ-004 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning mask_in is offered.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts a mask.
REQ-007 The block SHALL have port mask_in, input, W, the candidate mask; bit (x*S*S + y*S + v) = 1 means value v is excluded at column x, row y.
REQ-008 The block SHALL have port out_valid, output, 1, meaning the result is held.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-010 The block SHALL have port mask_out, output, W, the refined mask in the same encoding as mask_in.
REQ-011 The block SHALL have port solved, output, 1, meaning every cell has exactly one unmasked value.
REQ-012 The block SHALL have port contradiction, output, 1, meaning some cell has all S values masked.
REQ-013 The block SHALL have port timeout, output, 1, meaning MAX_ITER passes ran without reaching a fixpoint.
REQ-014 The block SHALL have port iter_count, output, 8, giving the number of passes executed.

Function
REQ-015 One pass SHALL be combinational, with next = cur OR elim.
REQ-016 Naked single rule: elim(x,y,v) SHALL be 1 if another cell in the same row, column or box has only v unmasked.
REQ-017 Hidden single rule: elim(x,y,u) SHALL be 1 for all u != v if v is masked in every other cell of some row, column or box containing (x,y), and v is unmasked at (x,y).
REQ-018 The mask SHALL only gain bits; no bit set in mask_in is ever cleared.
REQ-019 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-020 In IDLE, in_ready SHALL be 1; on in_valid&in_ready, mask_in is registered, iter_count is cleared, and the FSM moves to RUN.
REQ-021 In RUN, the block SHALL perform one pass per cycle and register next into the mask register, with iter_count incremented.
REQ-022 RUN SHALL exit to DONE in the priority contradiction, then fixpoint (next==cur), then iter_count reaching MAX_ITER; a fixpoint pass still counts as a pass.
REQ-023 contradiction SHALL be evaluated on the registered mask; a contradicting input therefore exits after 1 pass.
REQ-024 timeout SHALL be 1 only if the exit cause is the pass limit and the state is neither fixpoint nor contradiction.
REQ-025 solved SHALL be 1 only when contradiction is 0 and all S*S cells have a single unmasked bit.
REQ-026 In DONE, out_valid SHALL be 1 and mask_out, flags and iter_count SHALL be held stable until out_valid&out_ready, after which the FSM returns to IDLE.
REQ-027 in_ready SHALL be 0 in RUN and DONE; there is no input buffering.
REQ-028 Latency from acceptance to out_valid SHALL be iter_count+1 cycles, with a minimum of 2.
REQ-029 out_ready asserted early (before DONE) SHALL be ignored.

Reset
REQ-030 On rst, the state SHALL be IDLE; in_ready=1 and out_valid=0.
REQ-031 On rst, mask_out, solved, contradiction, timeout and iter_count SHALL all be 0.
REQ-032 rst SHALL override any handshake in the same cycle and abort RUN/DONE without producing output.

Structure
REQ-033 Package sudoku_pkg SHALL hold the state enum, an index function cell_bit(x,y,v,S), and the defaults for BOX and MAX_ITER.
REQ-034 The pass logic SHALL be a separate combinational sub-module sudoku_mask_pass, parameterised by BOX, that outputs next, contradiction and solved.

Verification
REQ-035 Scenario: all-zero mask -> no eliminations, out after 2 cycles, iter_count=1, solved=0, contradiction=0, timeout=0.
REQ-036 Scenario: cell(0,0) has only v=4 unmasked -> bit 4 masked in row 0, column 0 and box 0 except at (0,0); flags 0.
REQ-037 Scenario: cell(2,3) fully masked -> contradiction=1, iter_count=1, solved=0.
REQ-038 Scenario: a valid solved grid minus one value per cell's candidates -> solved=1 at fixpoint and mask_out equals the solution mask.
REQ-039 Scenario: MAX_ITER=1 with a chain needing 3 passes -> timeout=1, iter_count=1.
REQ-040 Scenario: out_ready held low 10 cycles, then rst asserted mid-RUN -> outputs stable while held, then all reset values; BOX=2 variant repeated.
